// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and bit positions within the {z,v,n} flag vector.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;
    localparam logic [2:0] ALU_SLL = 3'd6;
    localparam logic [2:0] ALU_SRA = 3'd7;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

endpackage

// File: rtl/alu_16_addsub.sv
// 16-bit add/subtract (a + b, or a + ~b + 1) with signed-overflow output.
// Purely combinational, zero latency; no flow control.
module alu_16_addsub (
    input  logic        sub,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        overflow
);

    logic [15:0] b_eff;

    assign b_eff = sub ? ~b : b;
    // The carry-out is deliberately dropped: arithmetic wraps modulo 2^16.
    assign sum      = a + b_eff + {15'd0, sub};
    assign overflow = (a[15] == b_eff[15]) && (sum[15] != a[15]);

endmodule

// File: rtl/alu_16.sv
// 16-bit ALU with combinational result/Z/V/N and a registered flag copy.
// Result and flags in the same cycle, flags_q one edge later; no flow control.
module alu_16
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  alu_op,
    input  logic [15:0] alu_a,
    input  logic [15:0] alu_b,
    input  logic        flag_en,
    output logic [15:0] alu_out,
    output logic        z,
    output logic        v,
    output logic        n,
    output logic [2:0]  flags_q
);

    logic [15:0]        sum;
    logic               sum_ovf;
    logic [3:0]         shamt;
    logic signed [15:0] a_signed;
    logic [15:0]        sra_res;
    logic [2:0]         flags;

    alu_16_addsub u_addsub (
        .sub      (alu_op == ALU_SUB),
        .a        (alu_a),
        .b        (alu_b),
        .sum      (sum),
        .overflow (sum_ovf)
    );

    assign shamt    = alu_b[3:0];
    assign a_signed = alu_a;
    assign sra_res  = a_signed >>> shamt;

    always_comb begin
        alu_out = '0;
        v       = 1'b0;
        case (alu_op)
            ALU_ADD, ALU_SUB: begin
                alu_out = sum;
                v       = sum_ovf;
            end
            ALU_AND: alu_out = alu_a & alu_b;
            ALU_OR:  alu_out = alu_a | alu_b;
            ALU_XOR: alu_out = alu_a ^ alu_b;
            ALU_NOT: alu_out = ~alu_a;
            ALU_SLL: alu_out = alu_a << shamt;
            ALU_SRA: alu_out = sra_res;
            default: alu_out = '0;
        endcase
    end

    assign z = (alu_out == 16'h0000);
    assign n = alu_out[15];

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = z;
        flags[FLAG_V] = v;
        flags[FLAG_N] = n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 3'b000;
        end else if (flag_en) begin
            flags_q <= flags;
        end
    end

endmodule

// File: tb/tb_alu_16.sv
// Directed-vector bench for alu_16: combinational result/flags and the flags_q register.
module tb_alu_16;

    logic        clk;
    logic        rst;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        flag_en;
    logic [15:0] alu_out;
    logic        z;
    logic        v;
    logic        n;
    logic [2:0]  flags_q;

    int tests_run;
    int tests_failed;

    alu_16 dut (
        .clk     (clk),
        .rst     (rst),
        .alu_op  (alu_op),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .flag_en (flag_en),
        .alu_out (alu_out),
        .z       (z),
        .v       (v),
        .n       (n),
        .flags_q (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    // Apply one vector and check result and {z,v,n} against hand-computed values.
    task automatic vec(input string tag, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp_out, input logic [2:0] exp_zvn);
        alu_op = op;
        alu_a  = a;
        alu_b  = b;
        #1;
        check({tag, ".out"}, alu_out, exp_out);
        check({tag, ".zvn"}, {13'd0, z, v, n}, {13'd0, exp_zvn});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst     = 1'b1;
        flag_en = 1'b0;
        alu_op  = 3'd0;
        alu_a   = 16'h0000;
        alu_b   = 16'h0000;

        // Register reset.
        @(negedge clk);
        @(posedge clk); #1;
        check("reset_flags_q", {13'd0, flags_q}, 16'h0000);

        @(negedge clk);
        rst = 1'b0;

        // Combinational vectors.            op    a         b         out       zvn
        vec("add_1_1",       3'd0, 16'h0001, 16'h0001, 16'h0002, 3'b000);
        vec("add_ovf_pos",   3'd0, 16'h7FFF, 16'h0001, 16'h8000, 3'b011);
        vec("add_m1_m1",     3'd0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 3'b001);
        vec("add_wrap_zero", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 3'b100);
        vec("add_ovf_neg",   3'd0, 16'h8000, 16'h8000, 16'h0000, 3'b110);
        vec("sub_ovf",       3'd1, 16'h8000, 16'h0001, 16'h7FFF, 3'b010);
        vec("sub_equal",     3'd1, 16'h0005, 16'h0005, 16'h0000, 3'b100);
        vec("sub_neg",       3'd1, 16'h0000, 16'h0001, 16'hFFFF, 3'b001);
        vec("sub_ovf_pos",   3'd1, 16'h7FFF, 16'hFFFF, 16'h8000, 3'b011);
        vec("and",           3'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b000);
        vec("or",            3'd3, 16'hF0F0, 16'h0FF0, 16'hFFF0, 3'b001);
        vec("xor",           3'd4, 16'hF0F0, 16'h0FF0, 16'hFF00, 3'b001);
        vec("xor_zero",      3'd4, 16'hA5A5, 16'hA5A5, 16'h0000, 3'b100);
        vec("not",           3'd5, 16'h00FF, 16'h1234, 16'hFF00, 3'b001);
        vec("not_zero",      3'd5, 16'hFFFF, 16'h0000, 16'h0000, 3'b100);
        vec("sll_15",        3'd6, 16'h0001, 16'h000F, 16'h8000, 3'b001);
        vec("sll_b_hi_zero", 3'd6, 16'h1234, 16'h0010, 16'h1234, 3'b000);
        vec("sll_no_v",      3'd6, 16'h7FFF, 16'h0001, 16'hFFFE, 3'b001);
        vec("sra_4_neg",     3'd7, 16'h8000, 16'h0004, 16'hF800, 3'b001);
        vec("sra_4_pos",     3'd7, 16'h7000, 16'h0004, 16'h0700, 3'b000);
        vec("sra_15_fill",   3'd7, 16'h8000, 16'hFFFF, 16'hFFFF, 3'b001);
        vec("sra_0",         3'd7, 16'h8421, 16'h0000, 16'h8421, 3'b001);

        // Capture flags of 0xFFFF+0x0001 -> {z,v,n} = 100.
        @(negedge clk);
        alu_op = 3'd0; alu_a = 16'hFFFF; alu_b = 16'h0001; flag_en = 1'b1;
        @(posedge clk); #1;
        check("flags_q_capture", {13'd0, flags_q}, 16'h0004);

        // Hold while flag_en is low even though the live flags change.
        @(negedge clk);
        flag_en = 1'b0; alu_a = 16'h7FFF;
        @(posedge clk); #1;
        check("flags_q_hold", {13'd0, flags_q}, 16'h0004);

        @(negedge clk);
        flag_en = 1'b1;
        @(posedge clk); #1;
        check("flags_q_capture2", {13'd0, flags_q}, 16'h0003);

        // Reset wins over flag_en; combinational path keeps tracking inputs.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("flags_q_rst_prio", {13'd0, flags_q}, 16'h0000);
        check("out_during_rst", alu_out, 16'h8000);
        check("zvn_during_rst", {13'd0, z, v, n}, 16'h0003);

        @(negedge clk);
        rst = 1'b0; flag_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_16.md
# alu_16

16-bit two's-complement arithmetic/logic unit for the project datapath's execute stage. Computes one of eight operations on two 16-bit operands selected by a 3-bit opcode, with same-cycle result and Z/V/N condition flags. A clocked flag register holds the last flags for branch and condition logic downstream.

## Interface
- No parameters; the data width is fixed at 16.
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- alu_op  in  3  operation select.
- alu_a  in  16  operand A.
- alu_b  in  16  operand B.
- flag_en  in  1  captures the current flags into flags_q at the clock edge.
- alu_out  out  16  result (combinational).
- z  out  1  zero flag (combinational).
- v  out  1  signed-overflow flag (combinational).
- n  out  1  negative flag (combinational).
- flags_q  out  3  registered {z,v,n}.

## Operation
- Opcodes:
  - 000 ADD: a+b.
  - 001 SUB: a−b.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOT: ~a, b ignored.
  - 110 SLL: a << b[3:0].
  - 111 SRA: a >>> b[3:0], arithmetic shift with sign fill.
- Arithmetic is modulo 2^16; the carry-out is discarded and not exported.
- SUB is implemented as a + ~b + 1 through the same adder.
- n = alu_out[15] for every opcode.
- z = 1 iff alu_out == 16'h0000, for every opcode.
- v for ADD: 1 iff a[15]==b[15] and alu_out[15]!=a[15].
- v for SUB: 1 iff a[15]!=b[15] and alu_out[15]!=a[15].
- v = 0 for all logic and shift opcodes.
- Shift amounts 0–15 use only b[3:0]; b[15:4] is ignored. A shift of 0 passes a through unchanged.
- The result and flags are a pure function of alu_op, alu_a and alu_b. They contain no X for known inputs.

## Timing
- alu_out, z, v, n are combinational with zero-cycle latency, valid within the same cycle the inputs settle.
- Reset does not affect the combinational outputs.
- flags_q updates at the rising edge of clk:
  - if rst: flags_q <= 3'b000.
  - else if flag_en: flags_q <= {z,v,n}.
  - otherwise it holds its value.
- rst has priority over flag_en when both are asserted in the same cycle.
- Reset mid-operation only clears flags_q; the combinational result continues to track the inputs.

## Structure
- Shared package alu_pkg holds:
  - the opcode constants (ALU_ADD=3'd0 … ALU_SRA=3'd7);
  - the flag bit indices (FLAG_Z=2, FLAG_V=1, FLAG_N=0).
- One sub-module, alu_16_addsub, is natural: it is a 16-bit adder with a sub input that inverts b and sets carry-in, and it outputs sum and overflow.
- The top level contains the opcode mux, the shifter, flag generation and the flags_q register.

## Test plan
- ADD 0x0001+0x0001 -> alu_out=0x0002, z=0 v=0 n=0.
- ADD 0x7FFF+0x0001 -> alu_out=0x8000, n=1 v=1 z=0.
- ADD 0xFFFF+0xFFFF -> alu_out=0xFFFE, n=1 v=0 z=0.
- ADD 0xFFFF+0x0001 -> alu_out=0x0000, z=1 v=0 n=0.
- SUB 0x8000−0x0001 -> 0x7FFF with v=1 n=0. Also:
  - AND 0xF0F0,0x0FF0 -> 0x00F0.
  - SRA 0x8000 by 4 -> 0xF800, n=1.
  - SLL 0x0001 by 15 -> 0x8000.
- flags_q register sequence:
  - assert rst one cycle -> flags_q=000.
  - apply ADD 0xFFFF+0x0001 with flag_en=1, then clock -> flags_q=100.
  - drop flag_en, change inputs, then clock -> flags_q unchanged.
  - rst and flag_en asserted together -> flags_q=000.
